// File: rtl/gusn_pkg.sv
// Shared fixed-point definitions for the weight multiplier server.
// Default Q8.8 format; modules re-derive limits from their own parameters.
package gusn_pkg;

    localparam int DEF_INT_W  = 8;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_NUM_W  = DEF_INT_W + DEF_FRAC_W;

    typedef logic signed [DEF_NUM_W-1:0] fx_t;

    localparam fx_t FX_MAX = {1'b0, {(DEF_NUM_W-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(DEF_NUM_W-1){1'b0}}};

    // Half an LSB of the result, added before the arithmetic shift.
    function automatic int round_k(input int frac_w);
        return (frac_w > 0) ? (1 << (frac_w - 1)) : 0;
    endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// One multiplier lane: full-width product in S1, round/saturate in S2.
// Holds both stages while stalled.
module fx_mul_sat
    import gusn_pkg::*;
#(
    parameter int NUM_W  = DEF_NUM_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_stall,
    input  logic [NUM_W-1:0] i_a,
    input  logic [NUM_W-1:0] i_w,
    output logic [NUM_W-1:0] o_res,
    output logic             o_ovf
);

    localparam int PW = 2 * NUM_W;
    localparam int RW = PW + 1;

    localparam logic signed [RW-1:0] LIM_HI =
        RW'((64'sd1 <<< (NUM_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] LIM_LO = ~LIM_HI;

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] r_prod;
    logic signed [RW-1:0] w_sum;
    logic signed [RW-1:0] w_shr;
    logic                 w_hi;
    logic                 w_lo;

    assign w_a    = PW'($signed(i_a));
    assign w_b    = PW'($signed(i_w));
    assign w_prod = w_a * w_b;

    // One guard bit keeps the rounding add from wrapping.
    assign w_sum = RW'(r_prod) + RW'(round_k(FRAC_W));
    assign w_shr = w_sum >>> FRAC_W;
    assign w_hi  = w_shr > LIM_HI;
    assign w_lo  = w_shr < LIM_LO;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod <= '0;
            o_res  <= '0;
            o_ovf  <= 1'b0;
        end else if (!i_stall) begin
            r_prod <= w_prod;
            if (w_hi) begin
                o_res <= LIM_HI[NUM_W-1:0];
            end else if (w_lo) begin
                o_res <= LIM_LO[NUM_W-1:0];
            end else begin
                o_res <= w_shr[NUM_W-1:0];
            end
            o_ovf <= w_hi | w_lo;
        end
    end

endmodule

// File: rtl/weight_mult_server.sv
// Weight RAM plus batched multiply pipeline (S0, S1, S2, OUT) with
// global stall on response backpressure.
module weight_mult_server
    import gusn_pkg::*;
#(
    parameter int INT_W      = DEF_INT_W,
    parameter int FRAC_W     = DEF_FRAC_W,
    parameter int BATCH_SIZE = 1,
    parameter int RAM_ADDR_W = 8,
    localparam int NUM_W     = INT_W + FRAC_W,
    localparam int ROW_W     = NUM_W * BATCH_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [RAM_ADDR_W-1:0] req_addr,
    input  logic [ROW_W-1:0]      req_v,
    input  logic                  wr_en,
    input  logic [RAM_ADDR_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]      wr_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ROW_W-1:0]      rsp_weight,
    output logic [ROW_W-1:0]      rsp_prod,
    output logic                  ovf_sticky
);

    logic [ROW_W-1:0] r_mem [0:(1<<RAM_ADDR_W)-1];

    logic             w_stall;
    logic             w_acc;
    logic             r_v0;
    logic             r_v1;
    logic             r_v2;
    logic [ROW_W-1:0] r_s0_v;
    logic [ROW_W-1:0] r_ram_q;
    logic [ROW_W-1:0] r_w1;
    logic [ROW_W-1:0] r_w2;
    logic [ROW_W-1:0] w_res;
    logic [BATCH_SIZE-1:0] w_ovf;

    assign w_stall   = rsp_valid && !rsp_ready;
    assign req_ready = !w_stall;
    assign w_acc     = req_valid && !w_stall;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Reads the pre-write row on a same-edge collision.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_ram_q <= r_mem[req_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_s0_v <= req_v;
            r_w1   <= r_ram_q;
            r_w2   <= r_w1;
        end
    end

    for (genvar g = 0; g < BATCH_SIZE; g++) begin : g_lane
        fx_mul_sat #(
            .NUM_W  (NUM_W),
            .FRAC_W (FRAC_W)
        ) u_mul (
            .clk     (clk),
            .reset   (reset),
            .i_stall (w_stall),
            .i_a     (r_s0_v[g*NUM_W +: NUM_W]),
            .i_w     (r_ram_q[g*NUM_W +: NUM_W]),
            .o_res   (w_res[g*NUM_W +: NUM_W]),
            .o_ovf   (w_ovf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_weight <= '0;
            rsp_prod   <= '0;
            ovf_sticky <= 1'b0;
        end else if (!w_stall) begin
            r_v0      <= w_acc;
            r_v1      <= r_v0;
            r_v2      <= r_v1;
            rsp_valid <= r_v2;
            if (r_v2) begin
                rsp_weight <= r_w2;
                rsp_prod   <= w_res;
                if (|w_ovf) begin
                    ovf_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_mult_server.sv
// Randomised and directed bench for weight_mult_server against a
// transaction-level model (row array + in-order response queue).
module tb_weight_mult_server;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [15:0] req_v;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_weight;
    logic [15:0] rsp_prod;
    logic        ovf_sticky;

    always #5 clk = ~clk;

    weight_mult_server dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_v      (req_v),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_weight (rsp_weight),
        .rsp_prod   (rsp_prod),
        .ovf_sticky (ovf_sticky)
    );

    typedef struct {
        logic [15:0] w;
        logic [15:0] p;
        bit          sat;
        bit          seen;
        int          acc_edge;
        int          acc_stall;
    } item_t;

    item_t       q[$];
    logic [15:0] mem_m [256];
    int          cyc = 0;
    int          nstall = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    bit          prev_rst = 1'b1;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_w;
    logic [15:0] prev_p;
    bit          sticky_m = 1'b0;
    bit          seen_rr0 = 1'b0;

    // Q8.8 product, round half up, saturate; returns {sat, result}.
    function automatic logic [16:0] model(input logic [15:0] a,
                                          input logic [15:0] w);
        longint p;
        longint r;
        logic [63:0] rv;
        p = longint'($signed(a)) * longint'($signed(w));
        r = (p + 128) >>> 8;
        if (r > 32767) return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        rv = r;
        return {1'b0, rv[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [16:0] m;
        if (reset) begin
            q.delete();
            sticky_m   = 1'b0;
            prev_rst   = 1'b1;
            prev_stall = 1'b0;
            if (wr_en) mem_m[wr_addr] = wr_data;
        end else begin
            if (prev_rst) begin
                chk("rst_valid", 32'(rsp_valid), 32'd0);
                chk("rst_weight", 32'(rsp_weight), 32'd0);
                chk("rst_prod", 32'(rsp_prod), 32'd0);
                chk("rst_ovf", 32'(ovf_sticky), 32'd0);
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_w", 32'(rsp_weight), 32'(prev_w));
                chk("hold_p", 32'(rsp_prod), 32'(prev_p));
            end
            chk("req_ready", 32'(req_ready),
                32'(!(rsp_valid && !rsp_ready)));
            if (!req_ready) seen_rr0 = 1'b1;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_weight", 32'(rsp_weight), 32'(q[0].w));
                    chk("rsp_prod", 32'(rsp_prod), 32'(q[0].p));
                    if (!q[0].seen) begin
                        chk("latency", 32'(cyc - q[0].acc_edge),
                            32'(3 + nstall - q[0].acc_stall));
                        q[0].seen = 1'b1;
                    end
                    sticky_m = sticky_m | q[0].sat;
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        n_pop++;
                    end
                end
            end
            chk("ovf_sticky", 32'(ovf_sticky), 32'(sticky_m));
            prev_stall = rsp_valid && !rsp_ready;
            prev_w = rsp_weight;
            prev_p = rsp_prod;
            if (prev_stall) nstall++;
            if (req_valid && req_ready) begin
                m = model(req_v, mem_m[req_addr]);
                q.push_back('{w: mem_m[req_addr], p: m[15:0],
                              sat: m[16], seen: 1'b0,
                              acc_edge: cyc + 1, acc_stall: nstall});
            end
            if (wr_en) mem_m[wr_addr] = wr_data;
            prev_rst = 1'b0;
        end
    end

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [15:0] v);
        int n = 0;
        req_valid = 1'b1;
        req_addr = a;
        req_v = v;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, input logic [15:0] ew,
                            input logic [15:0] ep);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_w"}, 32'(rsp_weight), 32'(ew));
        chk({nm, "_p"}, 32'(rsp_prod), 32'(ep));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_v = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rsp_ready = 1'b1;

        chk("pin_basic", 32'(model(16'h0180, 16'h0200)), 32'h00300);
        chk("pin_sat_pos", 32'(model(16'h6400, 16'h0200)), 32'h17FFF);
        chk("pin_sat_neg", 32'(model(16'h8000, 16'hFF00)), 32'h17FFF);
        chk("pin_rnd_up", 32'(model(16'h0001, 16'h0080)), 32'h00001);
        chk("pin_rnd_neg", 32'(model(16'hFFFF, 16'h0080)), 32'h00000);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) wr(8'(i), 16'($urandom));

        wr(8'd5, 16'h0200);
        send(8'd5, 16'h0180);
        wait_rsp("basic", 16'h0200, 16'h0300);
        chk("basic_ovf", 32'(ovf_sticky), 32'd0);

        wr(8'd6, 16'h0200);
        send(8'd6, 16'h6400);
        wait_rsp("sat_pos", 16'h0200, 16'h7FFF);
        chk("sat_pos_ovf", 32'(ovf_sticky), 32'd1);
        wr(8'd7, 16'hFF00);
        send(8'd7, 16'h8000);
        wait_rsp("sat_neg", 16'hFF00, 16'h7FFF);

        wr(8'd8, 16'h0080);
        send(8'd8, 16'h0001);
        wait_rsp("rnd_up", 16'h0080, 16'h0001);
        send(8'd8, 16'hFFFF);
        wait_rsp("rnd_neg", 16'h0080, 16'h0000);
        chk("sticky_hold", 32'(ovf_sticky), 32'd1);

        wr(8'd3, 16'h0100);
        wr_en = 1'b1;
        wr_addr = 8'd3;
        wr_data = 16'h0300;
        send(8'd3, 16'h0100);
        wr_en = 1'b0;
        wait_rsp("coll_old", 16'h0100, 16'h0100);
        send(8'd3, 16'h0100);
        wait_rsp("coll_new", 16'h0300, 16'h0300);

        n0 = n_pop;
        seen_rr0 = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(8'(i), 16'($urandom_range(0, 16'h0600)));
            end
            begin
                repeat (2) @(posedge clk);
                #1 rsp_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        repeat (15) @(posedge clk);
        #1;
        chk("bp_count", 32'(n_pop - n0), 32'd6);
        chk("bp_ready_drop", 32'(seen_rr0), 32'd1);

        for (int c = 0; c < 400; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_v = 16'($urandom);
            else req_v = 16'($urandom_range(0, 16'h0800) - 16'h0400);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = 8'($urandom_range(0, 15));
            wr_data = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wr_en = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);

        wr(8'd9, 16'h0140);
        wr(8'd6, 16'h0200);
        send(8'd6, 16'h6400);
        send(8'd9, 16'h0100);
        send(8'd9, 16'h0100);
        wait_rsp("pre_rst_sat", 16'h0200, 16'h7FFF);
        send(8'd9, 16'h0100);
        send(8'd9, 16'h0100);
        send(8'd9, 16'h0100);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_ovf", 32'(ovf_sticky), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        send(8'd9, 16'h0100);
        wait_rsp("ram_keep", 16'h0140, 16'h0140);
        repeat (5) @(posedge clk);
        #1;
        chk("final_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
